// File: rtl/latch_strobe_gen.sv
// Trigger-to-latch strobe generator: synchronises an async trigger, waits a
// programmable delay, fires a one-cycle latch strobe, then enforces a holdoff.
module latch_strobe_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             anrst,
  input  logic             enable,
  input  logic             trig,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] holdoff,
  output logic             latch,
  output logic             busy,
  output logic             missed,
  output logic [15:0]      strobe_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DELAY   = 2'd1;
  localparam logic [1:0] FIRE    = 2'd2;
  localparam logic [1:0] HOLDOFF = 2'd3;

  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             latch_q, busy_q, missed_q, missed_d;
  logic [15:0]      strobe_cnt_q, strobe_cnt_d;

  // Synchroniser resets high so a trigger held across reset release is not an edge.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= trig;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    missed_d     = enable & rise & (state_q != IDLE);
    strobe_cnt_d = strobe_cnt_q;
    if (state_q == FIRE) strobe_cnt_d = strobe_cnt_q + 16'd1;
    case (state_q)
      IDLE: begin
        if (enable && rise) begin
          hold_d = holdoff;
          if (delay == '0) begin
            state_d = FIRE;
          end else begin
            state_d = DELAY;
            cnt_d   = delay - 1'b1;
          end
        end
      end
      DELAY: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = FIRE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIRE: begin
        // The strobe already in flight is always completed and counted.
        if (!enable || hold_q == '0) begin
          state_d = IDLE;
        end else begin
          state_d = HOLDOFF;
          cnt_d   = hold_q - 1'b1;
        end
      end
      HOLDOFF: begin
        if (!enable || cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs come straight from flops decoded off the next state, so they never glitch.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hold_q       <= '0;
      latch_q      <= 1'b0;
      busy_q       <= 1'b0;
      missed_q     <= 1'b0;
      strobe_cnt_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      latch_q      <= (state_d == FIRE);
      busy_q       <= (state_d != IDLE);
      missed_q     <= missed_d;
      strobe_cnt_q <= strobe_cnt_d;
    end
  end

  assign latch      = latch_q;
  assign busy       = busy_q;
  assign missed     = missed_q;
  assign strobe_cnt = strobe_cnt_q;

endmodule

// File: tb/tb_latch_strobe_gen.sv
// Bench for latch_strobe_gen: directed scenarios plus random traffic, checked
// every cycle against an edge-number/timestamp model of the strobe sequence.
module tb_latch_strobe_gen;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             anrst = 1'b0;
  logic             enable = 1'b0;
  logic             trig = 1'b0;
  logic [CNT_W-1:0] delay = '0;
  logic [CNT_W-1:0] holdoff = '0;
  logic             latch, busy, missed;
  logic [15:0]      strobe_cnt;

  latch_strobe_gen #(.CNT_W(CNT_W)) dut (
    .clk(clk), .anrst(anrst), .enable(enable), .trig(trig),
    .delay(delay), .holdoff(holdoff),
    .latch(latch), .busy(busy), .missed(missed), .strobe_cnt(strobe_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: edge counter n; a sequence accepted at edge acc fires (latch high)
  // after edge fire and returns to idle at edge free.
  int n = 0;
  int acc, fire, free, exp_cnt;
  bit p1, p2, p3;
  bit exp_latch, exp_busy, exp_missed;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    acc = -10; fire = -10; free = -10; exp_cnt = 0;
    p1 = 1'b1; p2 = 1'b1; p3 = 1'b1;
    exp_latch = 1'b0; exp_busy = 1'b0; exp_missed = 1'b0;
  endtask

  task automatic model_edge(input bit t, input bit en, input int d, input int h);
    bit rise_now, busy_before;
    rise_now = p2 & ~p3;
    p3 = p2; p2 = p1; p1 = t;
    busy_before = (acc < n) && (n <= free);
    if (n == fire + 1) exp_cnt = (exp_cnt + 1) & 16'hFFFF;
    exp_missed = 1'b0;
    if (!en) begin
      if (busy_before) begin
        if (n <= fire) fire = -10;
        free = n;
      end
    end else if (rise_now) begin
      if (busy_before) begin
        exp_missed = 1'b1;
      end else begin
        acc  = n;
        fire = n + d;
        free = n + d + 1 + h;
      end
    end
    exp_latch = (n == fire);
    exp_busy  = (acc <= n) && (n < free);
  endtask

  task automatic check_all();
    chk("latch", {15'd0, latch}, {15'd0, exp_latch});
    chk("busy", {15'd0, busy}, {15'd0, exp_busy});
    chk("missed", {15'd0, missed}, {15'd0, exp_missed});
    chk("strobe_cnt", strobe_cnt, exp_cnt[15:0]);
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at the next falling edge.
  task automatic step(input bit t, input bit en, input int d, input int h);
    trig = t; enable = en; delay = CNT_W'(d); holdoff = CNT_W'(h);
    @(posedge clk);
    n++;
    if (!anrst) model_reset();
    else model_edge(t, en, d, h);
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input int k, input bit t, input bit en, input int d, input int h);
    for (int i = 0; i < k; i++) step(t, en, d, h);
  endtask

  task automatic async_reset_check(input string tag);
    anrst = 1'b0;
    #1;
    model_reset();
    chk({tag, "_latch"}, {15'd0, latch}, 16'd0);
    chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
    chk({tag, "_missed"}, {15'd0, missed}, 16'd0);
    chk({tag, "_cnt"}, strobe_cnt, 16'd0);
  endtask

  initial begin
    model_reset();
    steps(3, 1'b0, 1'b1, 0, 0);
    anrst = 1'b1;
    steps(4, 1'b0, 1'b1, 0, 0);
    $display("reset: strobe_cnt=%0h busy=%0b", strobe_cnt, busy);

    // Zero delay, zero holdoff.
    steps(1, 1'b1, 1'b1, 0, 0);
    steps(5, 1'b0, 1'b1, 0, 0);
    $display("d0h0: strobe_cnt=%0h", strobe_cnt);

    // delay 5, holdoff 3, inputs altered mid-sequence must not matter.
    steps(2, 1'b1, 1'b1, 5, 3);
    steps(3, 1'b0, 1'b1, 1, 0);
    steps(12, 1'b0, 1'b1, 7, 7);
    $display("d5h3: strobe_cnt=%0h", strobe_cnt);

    // Second rise during DELAY is missed.
    steps(1, 1'b1, 1'b1, 4, 0);
    steps(2, 1'b0, 1'b1, 4, 0);
    steps(1, 1'b1, 1'b1, 4, 0);
    steps(10, 1'b0, 1'b1, 4, 0);
    $display("missed-in-delay: strobe_cnt=%0h", strobe_cnt);

    // Rise landing on the HOLDOFF->IDLE edge is missed; one later is accepted.
    steps(1, 1'b1, 1'b1, 0, 2);
    steps(2, 1'b0, 1'b1, 0, 2);
    steps(1, 1'b1, 1'b1, 0, 2);
    steps(2, 1'b0, 1'b1, 0, 2);
    steps(1, 1'b1, 1'b1, 0, 0);
    steps(6, 1'b0, 1'b1, 0, 0);
    $display("holdoff-boundary: strobe_cnt=%0h", strobe_cnt);

    // Enable dropped in DELAY, then in FIRE, then with a rise in IDLE.
    steps(1, 1'b1, 1'b1, 6, 2);
    steps(4, 1'b0, 1'b1, 6, 2);
    steps(3, 1'b0, 1'b0, 6, 2);
    steps(1, 1'b1, 1'b1, 1, 4);
    steps(3, 1'b0, 1'b1, 1, 4);
    steps(3, 1'b0, 1'b0, 1, 4);
    steps(1, 1'b1, 1'b0, 0, 0);
    steps(4, 1'b0, 1'b0, 0, 0);
    $display("enable-drop: strobe_cnt=%0h", strobe_cnt);

    // Preload the strobe counter near the top, then wrap it.
    force dut.strobe_cnt_q = 16'hFFFD;
    exp_cnt = 16'hFFFD;
    steps(1, 1'b0, 1'b1, 0, 0);
    release dut.strobe_cnt_q;
    steps(2, 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      steps(1, 1'b1, 1'b1, 0, 0);
      steps(2, 1'b0, 1'b1, 0, 0);
    end
    steps(2, 1'b0, 1'b1, 0, 0);
    $display("wrap: strobe_cnt=%0h", strobe_cnt);

    // Trigger held high across reset release produces nothing.
    async_reset_check("rst_a");
    steps(2, 1'b1, 1'b1, 0, 0);
    anrst = 1'b1;
    steps(6, 1'b1, 1'b1, 0, 0);
    steps(3, 1'b0, 1'b1, 0, 0);
    $display("trig-through-reset: latch=%0b", latch);

    // Reset pulsed during HOLDOFF aborts at once.
    steps(1, 1'b1, 1'b1, 1, 6);
    steps(6, 1'b0, 1'b1, 1, 6);
    async_reset_check("rst_b");
    steps(2, 1'b0, 1'b1, 0, 0);
    anrst = 1'b1;
    steps(5, 1'b0, 1'b1, 0, 0);
    $display("reset-in-holdoff: busy=%0b", busy);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0),
           int'($urandom_range(0, 6)), int'($urandom_range(0, 5)));
    end
    $display("random: strobe_cnt=%0h", strobe_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/latch_strobe_gen.md
LATCH_STROBE_GEN -- requirements
Module: latch_strobe_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the delay and holdoff counters (legal range 1..16).
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 anrst  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  synchronous arm; 0 = ignore triggers and abort any sequence in progress.
REQ-005 trig  input  1  trigger level, asynchronous to clk.
REQ-006 delay  input  CNT_W  cycles from detected trigger edge to strobe.
REQ-007 holdoff  input  CNT_W  dead cycles after the strobe.
REQ-008 latch  output  1  one-cycle strobe, driven directly from a state register, glitch-free; drives the downstream data-hold stage's latch input.
REQ-009 busy  output  1  high whenever state != IDLE.
REQ-010 missed  output  1  one-cycle pulse when a trigger edge is dropped.
REQ-011 strobe_cnt  output  16  count of issued strobes, wraps 0xFFFF -> 0x0000.

Function
REQ-012 trig SHALL pass through a 2-flop synchronizer (s1, s2) plus one history flop s3; rise = s2 & ~s3.
REQ-013 If t is the first clk edge sampling trig high, rise SHALL be seen by the FSM at edge t+2.
REQ-014 The FSM SHALL have exactly the states IDLE, DELAY, FIRE, HOLDOFF; latch = (state == FIRE).
REQ-015 IDLE: on rise with enable=1, the block SHALL capture holdoff and go to FIRE if delay==0, else to DELAY with cnt = delay-1.
REQ-016 DELAY: at each edge, cnt SHALL decrement; when cnt==0, the FSM SHALL go to FIRE, so latch is high in the cycle after edge t+2+delay.
REQ-017 FIRE SHALL last exactly one cycle, then go to IDLE if the captured holdoff==0, else to HOLDOFF with cnt = holdoff-1.
REQ-018 HOLDOFF: cnt SHALL decrement each edge; at cnt==0 the FSM SHALL go to IDLE, so the next accepted rise is possible one edge later.
REQ-019 delay and holdoff SHALL be sampled only at the accepting edge; later changes SHALL NOT affect the sequence in progress.
REQ-020 A rise while state is DELAY, FIRE or HOLDOFF (enable=1) SHALL assert missed for exactly one cycle and SHALL NOT restart or extend the sequence.
REQ-021 A rise on the same edge as the HOLDOFF->IDLE transition SHALL count as missed.
REQ-022 With enable=0, rise in IDLE SHALL be ignored and missed SHALL stay 0.
REQ-023 enable falling while in DELAY or HOLDOFF SHALL force IDLE at the next edge, with no latch and no strobe_cnt change.
REQ-024 enable falling while in FIRE SHALL leave the already-high latch cycle intact, count it, and then go to IDLE.
REQ-025 strobe_cnt SHALL increment by 1 at the edge ending each FIRE cycle; the new value is visible in the cycle after latch.
REQ-026 The FSM SHALL ignore a rise while in FIRE; trig edges closer together than 3 cycles need not be resolved.

Reset
REQ-027 While anrst=0, the block SHALL hold state=IDLE, cnt=0, latch=0, busy=0, missed=0, strobe_cnt=0, captured holdoff=0.
REQ-028 s1, s2, s3 SHALL reset to 1, so trig held high across reset release produces no rise.
REQ-029 Reset asserted mid-sequence SHALL abort immediately and asynchronously; no latch pulse SHALL follow release unless a new rise occurs.

Verification
REQ-030 delay=0, holdoff=0, trig rises before edge 10 -> latch high only in the cycle after edge 12; strobe_cnt 0->1 after edge 13.
REQ-031 delay=5, holdoff=3, trig rises at edge 10 -> latch high after edge 17; busy high from after edge 12 through the HOLDOFF->IDLE edge 21.
REQ-032 delay=4, second trig rise detected during DELAY -> exactly one missed pulse, one latch, strobe_cnt=+1.
REQ-033 Preload strobe_cnt to 0xFFFF via 65535 strobes, then one more trigger -> strobe_cnt=0x0000; enable dropped during DELAY -> busy low next cycle, no latch.
REQ-034 trig held high through anrst release -> no latch; anrst pulsed low during HOLDOFF -> all outputs 0 immediately, IDLE after release.
